// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver with ASCII command decode for the fan panel.
// Each good frame gives a one-cycle rx_valid and, for a recognised letter,
// a one-cycle cmd_* pulse. A 0 stop bit gives one frame_err and the receiver
// then waits for the line to return high before hunting for the next start.
module uart_cmd_rx #(
    parameter int SYS_FREQ = 125,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       cmd_wind_inc,
    output logic       cmd_wind_back,
    output logic       cmd_fan_idle,
    output logic       cmd_led_toggle,
    output logic       cmd_rot_toggle,
    output logic       cmd_timer
);
    localparam int BIT  = SYS_FREQ * 1_000_000 / BAUD;
    localparam int HALF = BIT / 2;
    localparam int CW   = ($clog2(BIT + 1) > 14) ? $clog2(BIT + 1) : 14;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic          sync1, sync2, prev;
    logic [1:0]    warm;
    logic          armed;
    logic          start_det;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [5:0]    cmd_next;
    logic [5:0]    cmd_q;

    // Two-flop synchroniser for the asynchronous RX pin, plus edge history.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b0;
        end else begin
            sync1 <= uart_rx;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Arm edge detection only once the synchroniser holds real pin samples
    // and the line has been seen high, so a line stuck low at reset release
    // cannot fake a start edge from the flops' reset value.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            warm  <= 2'd0;
            armed <= 1'b0;
        end else begin
            if (warm != 2'd2) warm <= warm + 2'd1;
            if (warm == 2'd2 && sync2) armed <= 1'b1;
        end
    end

    assign start_det = armed && prev && !sync2;

    // Exact-match command decode of the assembled byte.
    always_comb begin
        cmd_next = 6'b0;
        case (shreg)
            8'h53, 8'h73: cmd_next[0] = 1'b1; // S s
            8'h42, 8'h62: cmd_next[1] = 1'b1; // B b
            8'h58, 8'h78: cmd_next[2] = 1'b1; // X x
            8'h4C, 8'h6C: cmd_next[3] = 1'b1; // L l
            8'h52, 8'h72: cmd_next[4] = 1'b1; // R r
            8'h54, 8'h74: cmd_next[5] = 1'b1; // T t
            default:      cmd_next    = 6'b0;
        endcase
    end

    // Frame FSM: mid-bit sampling from a single counter, registered pulses.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            cmd_q     <= 6'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            cmd_q     <= 6'b0;
            case (state)
                IDLE: begin
                    if (start_det) begin
                        cnt   <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == CW'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        state   <= sync2 ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CW'(BIT - 1)) begin
                        cnt     <= '0;
                        shreg   <= {sync2, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CW'(BIT - 1)) begin
                        cnt <= '0;
                        if (sync2) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                            cmd_q    <= cmd_next;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (sync2) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_wind_inc   = cmd_q[0];
    assign cmd_wind_back  = cmd_q[1];
    assign cmd_fan_idle   = cmd_q[2];
    assign cmd_led_toggle = cmd_q[3];
    assign cmd_rot_toggle = cmd_q[4];
    assign cmd_timer      = cmd_q[5];
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx at BIT=10, HALF=5. Stimulus pushes the
// hand-computed expected event; a monitor pops on every output pulse.
module tb_uart_cmd_rx;
    logic       clk;
    logic       reset_p;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err;
    logic       cmd_wind_inc, cmd_wind_back, cmd_fan_idle;
    logic       cmd_led_toggle, cmd_rot_toggle, cmd_timer;

    uart_cmd_rx #(.SYS_FREQ(1), .BAUD(100_000)) dut (
        .clk(clk), .reset_p(reset_p), .uart_rx(uart_rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .cmd_wind_inc(cmd_wind_inc), .cmd_wind_back(cmd_wind_back),
        .cmd_fan_idle(cmd_fan_idle), .cmd_led_toggle(cmd_led_toggle),
        .cmd_rot_toggle(cmd_rot_toggle), .cmd_timer(cmd_timer)
    );

    // cmd vector order: {timer, rot, led, idle, back, inc}
    typedef struct {
        logic       valid;
        logic       err;
        logic [7:0] data;
        logic [5:0] cmd;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [7:0] last_good = 8'h00;
    logic [5:0] cmd_vec;

    assign cmd_vec = {cmd_timer, cmd_rot_toggle, cmd_led_toggle,
                      cmd_fan_idle, cmd_wind_back, cmd_wind_inc};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every output pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset_p && (rx_valid || frame_err || cmd_vec != 6'b0)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b cmd=%b data=0x%0h at cycle %0d, expected none",
                         rx_valid, frame_err, cmd_vec, rx_data, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rx_valid", rx_valid, e.valid);
                check("frame_err", frame_err, e.err);
                check("rx_data", rx_data, e.data);
                check("cmd", cmd_vec, e.cmd);
                check("latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic bit_out(input logic v);
        uart_rx = v;
        repeat (10) @(negedge clk);
    endtask

    // Drive one frame from a negedge; expectation is pushed at the start edge.
    task automatic send(input logic [7:0] b, input logic stop_ok, input logic [5:0] ecmd);
        exp_t e;
        e.valid = stop_ok;
        e.err   = !stop_ok;
        e.data  = stop_ok ? b : last_good;
        e.cmd   = stop_ok ? ecmd : 6'b0;
        e.cyc   = cyc + 98;
        if (stop_ok) last_good = b;
        q.push_back(e);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop_ok);
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_rx_data"}, rx_data, 0);
        check({name, "_rx_valid"}, rx_valid, 0);
        check({name, "_frame_err"}, frame_err, 0);
        check({name, "_cmd"}, cmd_vec, 0);
    endtask

    logic [7:0] s_byte;

    initial begin
        reset_p = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_p = 1'b0;
        check_quiet("reset");
        idle(20);

        // Single 'S' with latency check
        send(8'h53, 1'b1, 6'b000001);
        idle(20);

        // Back-to-back, no idle gap
        send(8'h78, 1'b1, 6'b000100);
        send(8'h4C, 1'b1, 6'b001000);
        send(8'h72, 1'b1, 6'b010000);
        send(8'h74, 1'b1, 6'b100000);
        send(8'h62, 1'b1, 6'b000010);
        idle(20);

        // Non-command byte
        send(8'h41, 1'b1, 6'b000000);
        idle(20);

        // Broken stop bit followed by a held break, then a good 'S'
        send(8'h53, 1'b0, 6'b000000);
        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        idle(10);
        send(8'h53, 1'b1, 6'b000001);
        idle(20);

        // Short low glitch on idle line, then 'R'
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(30);
        send(8'h52, 1'b1, 6'b010000);
        idle(20);

        // Reset during data bit 4 of 'S'; released while the line is low
        s_byte = 8'h53;
        bit_out(1'b0);
        for (int i = 0; i < 3; i++) bit_out(s_byte[i]);
        uart_rx = s_byte[3];
        reset_p = 1'b1;
        repeat (5) @(negedge clk);
        check_quiet("in_reset");
        repeat (5) @(negedge clk);
        for (int i = 4; i < 7; i++) bit_out(s_byte[i]);
        uart_rx = s_byte[7];
        repeat (2) @(negedge clk);
        reset_p = 1'b0;
        last_good = 8'h00;
        repeat (8) @(negedge clk);
        bit_out(1'b1);
        idle(20);
        check_quiet("after_reset");
        send(8'h53, 1'b1, 6'b000001);

        // Bounded drain of outstanding expectations
        for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
        check("pending_events", q.size(), 0);
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

UART receiver and ASCII command decoder that lets a serial terminal drive the fan front panel. It deserialises 8N1 frames from a single RX pin and turns recognised command bytes into one-cycle pulses. Those pulses are OR-ed at the top level with the matching button and clap pulses: speed increment, speed back, stop, LED toggle, rotation start/stop and timer step. It is the receive-side counterpart of the existing string/frame transmit path.

## Interface
- SYS_FREQ, 125, system clock in MHz
- BAUD, 9600, line rate in bit/s; BIT = SYS_FREQ*1_000_000/BAUD (integer truncation, 13020 at defaults), HALF = BIT/2 (6510)
- clk  in  1  system clock, all logic on rising edge
- reset_p  in  1  reset, asynchronous, active-high
- uart_rx  in  1  serial line, idle high, asynchronous to clk
- rx_data  out  8  last correctly framed byte, held until next good frame
- rx_valid  out  1  one-cycle pulse per good frame
- frame_err  out  1  one-cycle pulse when stop bit samples 0
- cmd_wind_inc  out  1  pulse on 'S' or 's'
- cmd_wind_back  out  1  pulse on 'B' or 'b'
- cmd_fan_idle  out  1  pulse on 'X' or 'x'
- cmd_led_toggle  out  1  pulse on 'L' or 'l'
- cmd_rot_toggle  out  1  pulse on 'R' or 'r'
- cmd_timer  out  1  pulse on 'T' or 't'

## Operation
- Input sync: two flops, both reset to 1; the synced value feeds a prev flop that resets to 0.
- Start detect: prev=1 and synced=0. The line must be seen high at least once after reset before any frame is accepted.
- FSM states IDLE, START, DATA, STOP, WAIT_HIGH; a single counter (≥14 bits) and a 3-bit bit index.
- IDLE: on start detect, clear counter, go to START.
- START: at counter = HALF-1, resample. If 0, go to DATA with counter cleared. If 1, treat as a glitch and return to IDLE with no output.
- DATA: at each counter = BIT-1, shift in the synced bit LSB first and clear the counter. After the 8th bit, go to STOP.
- STOP: at counter = BIT-1, sample the line.
  - If 1: load rx_data, pulse rx_valid, decode, go to IDLE.
  - If 0: pulse frame_err, leave rx_data unchanged, decode nothing, go to WAIT_HIGH.
- WAIT_HIGH: stay until the synced line is 1, then IDLE. A break condition therefore yields exactly one frame_err.
- Decode: exact byte compare, upper or lower case per the port list. At most one cmd_* asserts per frame. Any other byte (including CR/LF) gives rx_valid only.
- All outputs are registered. cmd_*, rx_valid and frame_err are never wider than one cycle.

## Timing
- Reset values: rx_data=0x00; rx_valid, frame_err and all cmd_* = 0; FSM in IDLE; counters 0.
- Reset asserted mid-frame: the partial frame is discarded with no pulse. After release, a line already low does not start a frame until it has been high.
- Let t0 be the cycle start detect is true. Sample points:
  - start bit: t0+HALF
  - data bit k (k=1..8): t0+HALF+k*BIT
  - stop bit: t0+HALF+9*BIT
- Outputs (rx_valid, cmd_*, or frame_err) assert in the cycle after the stop sample, for exactly 1 cycle.
- Pin-to-detect latency is 2 cycles of synchroniser delay.
- Back-to-back frames: a start edge arriving any time after the stop sample is accepted. Minimum inter-frame gap is 0 idle bits at nominal baud.
- Tolerates ±2% baud mismatch, since mid-bit sampling drifts < 0.5 bit over 10 bits.

## Test plan
All scenarios use SYS_FREQ=1, BAUD=100_000, giving BIT=10 and HALF=5.
- Reset, line high, send 'S' (0x53) → rx_valid and cmd_wind_inc are each 1 for one cycle, 2+5+90+1 = 98 cycles after the pin falls. rx_data=0x53. All other cmd_* stay 0.
- Send 'x', 'L', 'r', 't', 'b' back-to-back with no idle gap → five rx_valid pulses, in order: cmd_fan_idle, cmd_led_toggle, cmd_rot_toggle, cmd_timer, cmd_wind_back.
- Send 0x41 'A' → rx_valid=1, rx_data=0x41, no cmd_* pulse.
- Send 0x53 with the stop bit forced 0, hold the line low 40 cycles, then release and send 'S' → exactly one frame_err, no cmd_wind_inc for the bad frame, rx_data unchanged. The following 'S' decodes normally.
- Low glitch of 3 cycles on an idle line → no output, FSM back in IDLE. A following 'R' decodes to cmd_rot_toggle.
- Assert reset_p at data bit 4 of 'S' while the line is low, release, then complete the waveform → no pulse for the truncated frame. The next full 'S' gives cmd_wind_inc.
